// File: rtl/simon_pkg.sv
// Shared constants, state codes and round helpers for the SIMON 128/192 core.
package simon_pkg;
  localparam int N  = 64;
  localparam int M  = 3;
  localparam int T  = 69;
  localparam int Co = 7;

  // Ascending range so that Z3[i] is bit i of the published sequence.
  localparam logic [0:61] Z3 =
    62'b11011011101011000110010111100000010010001010011100110100001111;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_KEYEXP = 4'd1,
    S_READY  = 4'd2,
    S_ROUND  = 4'd3,
    S_DONE   = 4'd4
  } state_e;

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
    return (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int s);
    return (a >> s) | (a << (N - s));
  endfunction

  function automatic logic [N-1:0] f(input logic [N-1:0] a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction
endpackage

// File: rtl/simon_key_expand.sv
// Round-key store: captures the 3 key words, then derives rk[3..68] one per cycle.
module simon_key_expand
  import simon_pkg::*;
(
  input  logic                  clk,
  input  logic                  nR,
  input  logic                  start,
  input  logic [M-1:0][N-1:0]   key,
  input  logic [Co-1:0]         rd_idx,
  output logic [N-1:0]          rd_key,
  output logic                  last,
  output logic                  loadKey,
  output logic                  doneKey
);
  logic [N-1:0]  rk_q [T];
  logic [Co-1:0] kcnt_q;
  logic          busy_q, loadKey_q, doneKey_q;
  logic [Co-1:0] zidx;
  logic [N-1:0]  tmp, rk_new;

  always_comb begin
    zidx = kcnt_q - Co'(3);
    if (zidx >= Co'(62)) zidx = zidx - Co'(62);
    tmp    = ror(rk_q[kcnt_q - Co'(1)], 3);
    tmp    = tmp ^ ror(tmp, 1);
    rk_new = ~rk_q[kcnt_q - Co'(3)] ^ tmp ^ {{(N-1){1'b0}}, Z3[zidx[5:0]]} ^ N'(3);
  end

  assign last    = busy_q && (kcnt_q == Co'(T-1));
  assign rd_key  = rk_q[rd_idx];
  assign loadKey = loadKey_q;
  assign doneKey = doneKey_q;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      for (int i = 0; i < T; i++) rk_q[i] <= '0;
      kcnt_q    <= '0;
      busy_q    <= 1'b0;
      loadKey_q <= 1'b0;
      doneKey_q <= 1'b0;
    end else begin
      loadKey_q <= start;
      if (start) begin
        for (int i = 0; i < M; i++) rk_q[i] <= key[i];
        kcnt_q    <= Co'(M);
        busy_q    <= 1'b1;
        doneKey_q <= 1'b0;
      end else if (busy_q) begin
        rk_q[kcnt_q] <= rk_new;
        if (last) begin
          busy_q    <= 1'b0;
          doneKey_q <= 1'b1;
        end else begin
          kcnt_q <= kcnt_q + Co'(1);
        end
      end
    end
  end
endmodule

// File: rtl/simon_128_192.sv
// Iterative SIMON 128/192: data FSM, round counter and one-round-per-cycle datapath.
module simon_128_192
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                nR,
  input  logic                newKey,
  input  logic [M-1:0][N-1:0] KEY,
  output logic                loadKey,
  output logic                doneKey,
  input  logic                newData,
  input  logic [1:0][N-1:0]   blockIN,
  input  logic                enc_dec,
  output logic                loadData,
  output logic                doneData,
  input  logic                readData,
  output logic [1:0][N-1:0]   outData,
  output logic [3:0]          mode
);
  state_e        state_q;
  logic [Co-1:0] rcnt_q, rd_idx;
  logic [N-1:0]  x_q, y_q, xn, yn, rd_key;
  logic          enc_q, loadData_q, doneData_q, key_start, key_last;
  logic [1:0][N-1:0] out_q;

  assign key_start = newKey && (state_q == S_IDLE || state_q == S_READY);
  // Decrypt walks the key schedule backwards.
  assign rd_idx    = enc_q ? rcnt_q : Co'(T-1) - rcnt_q;

  simon_key_expand u_kexp (
    .clk     (clk),
    .nR      (nR),
    .start   (key_start),
    .key     (KEY),
    .rd_idx  (rd_idx),
    .rd_key  (rd_key),
    .last    (key_last),
    .loadKey (loadKey),
    .doneKey (doneKey)
  );

  always_comb begin
    xn = enc_q ? (y_q ^ f(x_q) ^ rd_key) : y_q;
    yn = enc_q ? x_q : (x_q ^ f(y_q) ^ rd_key);
  end

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q    <= S_IDLE;
      rcnt_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      enc_q      <= 1'b0;
      loadData_q <= 1'b0;
      doneData_q <= 1'b0;
      out_q      <= '0;
    end else begin
      loadData_q <= 1'b0;
      case (state_q)
        S_IDLE:   if (newKey) state_q <= S_KEYEXP;
        S_KEYEXP: if (key_last) state_q <= S_READY;
        S_READY: begin
          if (newKey) begin
            state_q <= S_KEYEXP;
          end else if (newData) begin
            x_q        <= blockIN[1];
            y_q        <= blockIN[0];
            enc_q      <= enc_dec;
            rcnt_q     <= '0;
            loadData_q <= 1'b1;
            state_q    <= S_ROUND;
          end
        end
        S_ROUND: begin
          x_q <= xn;
          y_q <= yn;
          if (rcnt_q == Co'(T-1)) begin
            out_q      <= {xn, yn};
            doneData_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            rcnt_q <= rcnt_q + Co'(1);
          end
        end
        S_DONE: begin
          if (readData) begin
            doneData_q <= 1'b0;
            state_q    <= S_READY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign loadData = loadData_q;
  assign doneData = doneData_q;
  assign outData  = out_q;
  assign mode     = state_q;
endmodule

// File: tb/tb_simon_128_192.sv
// Scoreboard bench for simon_128_192 against a behavioural SIMON model.
module tb_simon_128_192;
  logic clk = 1'b0;
  logic nR = 1'b0;
  logic newKey = 1'b0, newData = 1'b0, enc_dec = 1'b0, readData = 1'b0;
  logic [2:0][63:0] KEY = '0;
  logic [1:0][63:0] blockIN = '0;
  logic loadKey, doneKey, loadData, doneData;
  logic [1:0][63:0] outData;
  logic [3:0] mode;

  int checks = 0, errors = 0;
  logic [127:0] sb[$];
  logic prev_done = 1'b0;

  localparam logic [191:0] TV_KEY = 192'h1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] TV_PT  = 128'h206572656874206e6568772065626972;
  localparam logic [127:0] TV_CT  = 128'hc4ac61effcdc0d4f6c9c8d6e2597b85b;

  simon_128_192 dut (
    .clk(clk), .nR(nR), .newKey(newKey), .KEY(KEY), .loadKey(loadKey), .doneKey(doneKey),
    .newData(newData), .blockIN(blockIN), .enc_dec(enc_dec), .loadData(loadData),
    .doneData(doneData), .readData(readData), .outData(outData), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] a, input int s);
    return (a >> s) | (a << (64 - s));
  endfunction
  function automatic logic [63:0] rotl(input logic [63:0] a, input int s);
    return (a << s) | (a >> (64 - s));
  endfunction
  function automatic logic [63:0] fm(input logic [63:0] a);
    return (rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2);
  endfunction

  function automatic logic [127:0] model(input logic [191:0] key, input logic [127:0] blk, input bit enc);
    string z = "11011011101011000110010111100000010010001010011100110100001111";
    logic [63:0] k[69];
    logic [63:0] x, y, t, c;
    for (int i = 0; i < 3; i++) k[i] = key[64*i +: 64];
    for (int i = 3; i < 69; i++) begin
      t = rotr(k[i-1], 3);
      t = t ^ rotr(t, 1);
      c = (z[(i-3) % 62] == "1") ? 64'd1 : 64'd0;
      k[i] = ~k[i-3] ^ t ^ c ^ 64'd3;
    end
    x = blk[127:64];
    y = blk[63:0];
    for (int r = 0; r < 69; r++) begin
      if (enc) {x, y} = {y ^ fm(x) ^ k[r], x};
      else     {x, y} = {y, x ^ fm(y) ^ k[68-r]};
    end
    return {x, y};
  endfunction

  // Monitor: one comparison per completed block.
  always @(negedge clk) begin
    if (!nR) prev_done = 1'b0;
    else begin
      if (doneData && !prev_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %h expected none", outData);
        end else chk("outData", outData, sb.pop_front());
      end
      prev_done = doneData;
    end
  end

  task automatic load_key(input logic [191:0] k);
    int n;
    @(negedge clk);
    newKey = 1'b1; KEY = k;
    @(negedge clk);
    newKey = 1'b0;
    chk("loadKey_pulse", loadKey, 1);
    chk("doneKey_low", doneKey, 0);
    chk("mode_keyexp", mode, 1);
    n = 0;
    while (!doneKey && n < 200) begin
      @(negedge clk); n++;
      if (n == 1) chk("loadKey_one_cycle", loadKey, 0);
    end
    chk("keyexp_latency", n, 66);
    chk("mode_ready", mode, 2);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!doneData && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic run_block(input logic [127:0] blk, input bit enc, input logic [127:0] exp);
    int n;
    @(negedge clk);
    newData = 1'b1; blockIN = blk; enc_dec = enc;
    sb.push_back(exp);
    @(negedge clk);
    newData = 1'b0;
    chk("loadData_pulse", loadData, 1);
    chk("mode_round", mode, 3);
    wait_done(n);
    chk("data_latency", n, 69);
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    chk("doneData_clear", doneData, 0);
    chk("mode_after_read", mode, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p[5], c[5], hold_o, blk;
    logic [191:0] rk;
    bit ok, enc;
    int n;
    p[0] = 128'ha8d5f7de0123fedc01234567fedcba98;
    p[1] = 128'h5bc92d014567ba9889abcdef01234567;
    p[2] = 128'hf2b48d4589ab765401234567fedcba98;
    p[3] = 128'h567f11decdef321089abcdef01234567;
    p[4] = TV_PT;

    repeat (3) @(negedge clk);
    chk("rst_loadKey", loadKey, 0);
    chk("rst_doneKey", doneKey, 0);
    chk("rst_loadData", loadData, 0);
    chk("rst_doneData", doneData, 0);
    chk("rst_outData", outData, 0);
    chk("rst_mode", mode, 0);
    nR = 1'b1;

    // newKey and newData together from IDLE: key first, then the block.
    @(negedge clk);
    newKey = 1'b1; newData = 1'b1; KEY = TV_KEY; blockIN = TV_PT; enc_dec = 1'b1;
    sb.push_back(TV_CT);
    @(negedge clk);
    newKey = 1'b0;
    chk("prio_loadKey", loadKey, 1);
    ok = !loadData; n = 0;
    while (!doneKey && n < 200) begin @(negedge clk); n++; if (loadData) ok = 1'b0; end
    chk("prio_no_early_load", ok, 1);
    chk("prio_keyexp_latency", n, 66);
    @(negedge clk);
    newData = 1'b0;
    chk("prio_loadData", loadData, 1);
    wait_done(n);
    chk("prio_data_latency", n, 69);

    // DONE hold with newData asserted.
    newData = 1'b1; blockIN = 128'h0123456789abcdef0123456789abcdef;
    hold_o = outData; ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!doneData || outData !== hold_o || loadData || mode != 4'd4) ok = 1'b0;
    end
    chk("done_hold", ok, 1);
    newData = 1'b0; readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    chk("done_exit_doneData", doneData, 0);
    chk("done_exit_mode", mode, 2);
    chk("done_exit_outData_kept", outData, TV_CT);

    run_block(TV_CT, 1'b0, TV_PT);

    for (int i = 0; i < 5; i++) begin
      c[i] = model(TV_KEY, p[i], 1'b1);
      run_block(p[i], 1'b1, c[i]);
    end
    @(negedge clk); nR = 1'b0;
    @(negedge clk); nR = 1'b1;
    load_key(TV_KEY);
    for (int i = 0; i < 5; i++) run_block(c[i], 1'b0, p[i]);

    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    load_key(rk);
    for (int i = 0; i < 6; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      enc = 1'($urandom_range(0, 1));
      run_block(blk, enc, model(rk, blk, enc));
    end

    // Reset during round 30 aborts everything and invalidates the key.
    @(negedge clk);
    newData = 1'b1; blockIN = TV_PT; enc_dec = 1'b1;
    @(negedge clk);
    newData = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_abort_mode", mode, 3);
    nR = 1'b0;
    #1;
    chk("abort_outputs", {loadKey, doneKey, loadData, doneData}, 0);
    chk("abort_outData", outData, 0);
    chk("abort_mode", mode, 0);
    @(negedge clk);
    nR = 1'b1; newData = 1'b1;
    ok = 1'b1;
    repeat (10) begin @(negedge clk); if (loadData || mode != 4'd0) ok = 1'b0; end
    newData = 1'b0;
    chk("no_service_without_key", ok, 1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/simon_128_192.md
# simon_128_192

Iterative SIMON 128/192 block-cipher core: one 128-bit block per operation, 192-bit key, 69 rounds, one round per clock. Accepts a key through a newKey/loadKey/doneKey handshake, expands and stores all round keys, then encrypts or decrypts blocks through a newData/loadData/doneData/readData handshake. Sits behind a host or bus wrapper that supplies key and data words and collects results.

## Interface
- N, 64: word size; a block is 2 words.
- M, 3: key words.
- T, 69: rounds and stored round keys.
- Co, 7: round/key counter width; must satisfy 2^Co > T.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nR  in  1  reset, asynchronous, active-low.
- newKey  in  1  request to load KEY.
- KEY  in  [M-1:0][N-1:0]  key; KEY[0] is k0, the least significant word.
- loadKey  out  1  one-cycle pulse: KEY captured.
- doneKey  out  1  level: all T round keys valid.
- newData  in  1  request to process blockIN.
- blockIN  in  [1:0][N-1:0]  input block; [1] is x (upper word), [0] is y.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled when the block is captured.
- loadData  out  1  one-cycle pulse: blockIN captured.
- doneData  out  1  level: outData valid; held until readData is seen.
- readData  in  1  host has read outData.
- outData  out  [1:0][N-1:0]  result; [1] = x, [0] = y.
- mode  out  4  current FSM state code.

## Operation
- States and mode codes: IDLE = 0 (no valid key), KEYEXP = 1, READY = 2, ROUND = 3, DONE = 4.
- IDLE or READY, newKey = 1:
  - capture KEY into rk[0..2]; pulse loadKey; clear doneKey; go to KEYEXP.
  - newKey has priority over newData.
- KEYEXP, for i = 3..68:
  - t = ROR3(rk[i-1]) ^ ROR1(ROR3(rk[i-1]))
  - rk[i] = ~rk[i-3] ^ t ^ z3[(i-3) mod 62] ^ 3
  - z3 bit sequence from index 0: 11011011101011000110010111100000010010001010011100110100001111.
  - After rk[68] is written: doneKey = 1, go to READY.
- READY, newData = 1 and newKey = 0:
  - capture blockIN into (x, y); latch enc_dec; pulse loadData; go to ROUND.
  - newData in IDLE or KEYEXP is not serviced until READY is reached.
- ROUND, round r = 0..68, with f(a) = (ROL1 a & ROL8 a) ^ ROL2 a:
  - encrypt: x' = y ^ f(x) ^ rk[r]; y' = x.
  - decrypt: x' = y; y' = x ^ f(y) ^ rk[68-r].
  - After round 68: outData = (x, y); doneData = 1; go to DONE.
- DONE:
  - hold outData and doneData.
  - readData = 1 → clear doneData, go to READY; outData keeps its value.
  - newData and newKey are ignored in DONE.
- readData outside DONE has no effect.
- A new key replaces all round keys; doneKey stays low until the new expansion completes.

## Timing
- Reset values: loadKey = 0, doneKey = 0, loadData = 0, doneData = 0, outData = 0, mode = 0 (IDLE). Round-key store and counters are cleared.
- Reset mid-operation: everything aborts to IDLE and keys are invalidated; a key must be reloaded.
- Key path, with edge K0 capturing KEY:
  - loadKey is high for the cycle after K0.
  - Expansion takes 66 edges (K1..K66); doneKey is high after K66.
- Data path, with edge D0 capturing the block:
  - loadData is high for the cycle after D0.
  - Rounds run on D1..D69; doneData is high after D69.
  - Capture-to-done latency is 69 cycles.
- DONE exit: the edge that samples readData = 1 clears doneData and moves to READY.
  - A newData held high may then be captured on the next edge.
- All outputs are registered.

## Structure
- Package simon_pkg holds:
  - the 62-bit z3 constant;
  - the state enum and its 4-bit codes;
  - default N, M, T, Co;
  - functions rol/ror and f.
- Natural sub-module: simon_key_expand, which owns the rk[0..T-1] store, the expansion counter, and the loadKey/doneKey outputs.
- Top level holds the data FSM, round counter, round datapath and outData register.

## Test plan
- Encrypt: key 1716151413121110_0f0e0d0c0b0a0908_0706050403020100, block 206572656874206e6568772065626972 → loadKey pulse, doneKey after 66 cycles, outData = c4ac61effcdc0d4f6c9c8d6e2597b85b.
- Decrypt: same key, block c4ac61effcdc0d4f6c9c8d6e2597b85b, enc_dec = 0 → outData = 206572656874206e6568772065626972.
- Stream of 5 blocks a8d5f7de0123fedc01234567fedcba98, 5bc92d014567ba9889abcdef01234567, f2b48d4589ab765401234567fedcba98, 567f11decdef321089abcdef01234567, plus the test vector:
  - encrypt all 5, reset, decrypt the 5 results;
  - each decrypted output equals the original plaintext.
- newData and newKey raised together from IDLE → key handled first; loadData only after doneKey.
- DONE hold: keep readData = 0 for 20 cycles → doneData and outData stable, newData not captured; then readData = 1 → doneData falls on the next edge.
- Drop nR during round 30 → all outputs return to 0 and mode = 0 immediately; a later newData is not serviced until a key is loaded.
